shift_rotate_pipe_ctrl: RTL and testbench
=========================================

Name: shift_rotate_pipe_ctrl

Overview:
- Issue-side controller and 3-stage pipeline for the SPU halfword/word shift-rotate datapath.
- Accepts decoded shift/rotate instructions from the issue stage and selects the shift count (register RB or sign-extended imm7).
- Sequences the operation through the datapath and presents ordered results to the register-file writeback arbiter under valid/ready backpressure, with flush support.

Parameters:
- REG_ADDR_W, 7, register-file address width (128 registers).
- DATA_W, 128, register width; fixed, not to be overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  issue stage presents an instruction.
- in_ready  output  1  controller accepts the instruction this cycle.
- in_op  input  3  opcode, spu_shift_pkg::shift_op_t.
- in_ra  input  128  operand RA.
- in_rb  input  128  operand RB; supplies per-element counts for register forms.
- in_imm7  input  7  immediate for immediate forms.
- in_rt  input  REG_ADDR_W  destination register.
- flush  input  1  branch-mispredict or exception squash.
- out_valid  output  1  result available.
- out_ready  input  1  writeback arbiter accepts the result.
- out_rt  output  REG_ADDR_W  destination of the result.
- out_data  output  128  result.
- busy  output  1  any stage valid.

Behaviour:
- Opcodes:
  - SHLH=0, SHLHI=1, ROTH=2, ROTHI=3 operate on 8 halfwords, element i = [16i+:16].
  - SHL=4, SHLI=5, ROT=6, ROTI=7 operate on 4 words, element i = [32i+:32].
- Count source:
  - Immediate forms: imm7 sign-extended to 16 bits, the same value for all elements.
  - Register forms: the low 16 bits of the same-index element of RB.
- Count masking:
  - SHLH/SHLHI: count & 0x1F; count >= 16 gives 0.
  - SHL/SHLI: count & 0x3F; count >= 32 gives 0.
  - ROTH/ROTHI: count & 0xF.
  - ROT/ROTI: count & 0x1F.
- Shift-left direction: toward the MSB (element << count); vacated bits are 0. Rotate left is circular.
- Stages:
  - S1 (capture): op, ra, resolved per-element counts, rt.
  - S2 (compute): datapath output registered.
  - S3 (hold): drives out_*.
- Each stage has a valid bit.
- Advance rule:
  - S3 frees when !s3_valid or out_ready.
  - S2 moves when S3 frees or !s2_valid. S1 likewise.
  - in_ready = S1 can move. Issue handshake is in_valid && in_ready.
- Latency: 3 cycles from an accepted issue to out_valid, with no backpressure. Throughput is 1 per cycle.
- Backpressure: with out_ready held low the pipeline fills to 3 entries, then in_ready=0. No loss, no reorder, no duplication.
- out_data/out_rt must be held stable while out_valid && !out_ready.
- Flush:
  - Next edge clears all valid bits; the data registers are don't-care.
  - Flush overrides a simultaneous issue, which is dropped.
  - in_ready is forced 0 during flush.
  - out_valid may still be high in the flush cycle; a handshake in that cycle counts as completed.
- Reset (asynchronous, any time including mid-operation):
  - All valid bits are 0; out_valid=0, busy=0.
  - out_data=0, out_rt=0, and internal data registers 0.
  - in_ready=1 in the first cycle after reset deasserts.
- busy = s1_valid | s2_valid | s3_valid.
- Undefined opcodes do not exist; the 3-bit encoding is fully used.

Decomposition:
- spu_shift_pkg:
  - shift_op_t enum.
  - HW_ELEMS=8, WD_ELEMS=4.
  - Count masks 0x1F/0x3F/0xF/0x1F.
  - Zero thresholds 16/32.
- Sub-module shift_rotate_datapath: purely combinational. Takes op, ra and 8 x 16-bit counts, returns 128-bit results for all opcodes. Instanced once between S1 and S2.
- Controller: valid/stall logic, count resolution, registers.

Test Plan:
- SHLHI, all RA halfwords 16'h0001, imm7=7'd4 -> 3 cycles later out_valid=1, out_data = eight 16'h0010, out_rt matches.
- SHLHI imm7=7'h7F (sign-extends to -1, masked to 31) -> all halfwords 0. SHLH with RB element 16'd15 on 16'hFFFF -> 16'h8000.
- ROTHI 16'h8001 by imm7=1 -> 16'h0003. ROTI word 32'h80000001 by imm7=7'h7F (count 31) -> 32'hC0000000.
- out_ready=0 and 4 back-to-back issues:
  - in_ready drops after the third issue.
  - Releasing out_ready produces results 1..4 in order, one per cycle, with held data stable during the stall.
- Flush with 2 in flight plus a concurrent issue:
  - Next cycle busy=0, no out_valid.
  - A subsequent issue completes normally in 3 cycles.
- Assert rst mid-stream with 3 in flight -> out_valid/out_data/out_rt/busy go 0 immediately. After release, in_ready=1 and a fresh SHL by 1 on 32'h1 gives 32'h2.

Source files
------------

// File: rtl/spu_shift_pkg.sv
// spu_shift_pkg: opcode encoding and element/count constants for the SPU shift-rotate pipe
package spu_shift_pkg;
  typedef enum logic [2:0] {
    SHLH  = 3'd0,
    SHLHI = 3'd1,
    ROTH  = 3'd2,
    ROTHI = 3'd3,
    SHL   = 3'd4,
    SHLI  = 3'd5,
    ROT   = 3'd6,
    ROTI  = 3'd7
  } shift_op_t;
  localparam int HW_ELEMS = 8;
  localparam int WD_ELEMS = 4;
  localparam logic [15:0] HW_SHL_MASK = 16'h001F;
  localparam logic [15:0] WD_SHL_MASK = 16'h003F;
  localparam logic [15:0] HW_ROT_MASK = 16'h000F;
  localparam logic [15:0] WD_ROT_MASK = 16'h001F;
  localparam logic [15:0] HW_ZERO = 16'd16;
  localparam logic [15:0] WD_ZERO = 16'd32;
endpackage

// File: rtl/shift_rotate_datapath.sv
// shift_rotate_datapath: combinational halfword/word shift-left and rotate-left on 128-bit operands
module shift_rotate_datapath
  import spu_shift_pkg::*;
(
  input  shift_op_t        op,
  input  logic [127:0]     ra,
  input  logic [7:0][15:0] cnt,
  output logic [127:0]     res
);
  logic         w_rot;
  logic         w_word;
  logic [127:0] w_h;
  logic [127:0] w_w;
  assign w_rot  = op inside {ROTH, ROTHI, ROT, ROTI};
  assign w_word = op inside {SHL, SHLI, ROT, ROTI};
  for (genvar i = 0; i < HW_ELEMS; i++) begin : g_h
    logic [15:0] w_e, w_ms, w_mr;
    logic [31:0] w_r;
    assign w_e  = ra[16*i+:16];
    assign w_ms = cnt[i] & HW_SHL_MASK;
    assign w_mr = cnt[i] & HW_ROT_MASK;
    assign w_r  = {w_e, w_e} << w_mr;
    assign w_h[16*i+:16] = w_rot ? w_r[31:16] : (w_ms >= HW_ZERO ? 16'h0 : w_e << w_ms);
  end
  for (genvar i = 0; i < WD_ELEMS; i++) begin : g_w
    logic [31:0] w_e;
    logic [15:0] w_ms, w_mr;
    logic [63:0] w_r;
    assign w_e  = ra[32*i+:32];
    assign w_ms = cnt[i] & WD_SHL_MASK;
    assign w_mr = cnt[i] & WD_ROT_MASK;
    assign w_r  = {w_e, w_e} << w_mr;
    assign w_w[32*i+:32] = w_rot ? w_r[63:32] : (w_ms >= WD_ZERO ? 32'h0 : w_e << w_ms);
  end
  assign res = w_word ? w_w : w_h;
endmodule

// File: rtl/shift_rotate_pipe_ctrl.sv
// shift_rotate_pipe_ctrl: 3-stage issue/compute/hold pipeline around the shift-rotate datapath
module shift_rotate_pipe_ctrl
  import spu_shift_pkg::*;
#(
  parameter int REG_ADDR_W = 7,
  parameter int DATA_W     = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  shift_op_t             in_op,
  input  logic [DATA_W-1:0]     in_ra,
  input  logic [DATA_W-1:0]     in_rb,
  input  logic [6:0]            in_imm7,
  input  logic [REG_ADDR_W-1:0] in_rt,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_rt,
  output logic [DATA_W-1:0]     out_data,
  output logic                  busy
);
  logic                  r_s1_v, r_s2_v, r_s3_v;
  shift_op_t             r_s1_op;
  logic [DATA_W-1:0]     r_s1_ra, r_s2_data, r_s3_data;
  logic [7:0][15:0]      r_s1_cnt;
  logic [REG_ADDR_W-1:0] r_s1_rt, r_s2_rt, r_s3_rt;
  logic                  w_s3_free, w_s2_mv, w_s1_mv;
  logic                  w_word, w_imm_form;
  logic [15:0]           w_imm;
  logic [7:0][15:0]      w_cnt;
  logic [DATA_W-1:0]     w_dp_res;
  assign w_s3_free  = !r_s3_v || out_ready;
  assign w_s2_mv    = w_s3_free || !r_s2_v;
  assign w_s1_mv    = w_s2_mv || !r_s1_v;
  assign in_ready   = w_s1_mv && !flush;
  assign out_valid  = r_s3_v;
  assign out_data   = r_s3_data;
  assign out_rt     = r_s3_rt;
  assign busy       = r_s1_v || r_s2_v || r_s3_v;
  assign w_word     = in_op inside {SHL, SHLI, ROT, ROTI};
  assign w_imm_form = in_op inside {SHLHI, ROTHI, SHLI, ROTI};
  assign w_imm      = {{9{in_imm7[6]}}, in_imm7};
  for (genvar i = 0; i < HW_ELEMS; i++) begin : g_cnt
    if (i < WD_ELEMS) begin : g_lo
      assign w_cnt[i] = w_imm_form ? w_imm : w_word ? in_rb[32*i+:16] : in_rb[16*i+:16];
    end else begin : g_hi
      assign w_cnt[i] = w_imm_form ? w_imm : w_word ? 16'h0 : in_rb[16*i+:16];
    end
  end
  shift_rotate_datapath u_dp (
    .op  (r_s1_op),
    .ra  (r_s1_ra),
    .cnt (r_s1_cnt),
    .res (w_dp_res)
  );
  // Stage registers: each stage loads from its predecessor when it is free to move; flush drops all valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s3_v    <= 1'b0;
      r_s1_op   <= SHLH;
      r_s1_ra   <= '0;
      r_s1_cnt  <= '0;
      r_s1_rt   <= '0;
      r_s2_data <= '0;
      r_s2_rt   <= '0;
      r_s3_data <= '0;
      r_s3_rt   <= '0;
    end else if (flush) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_s3_v <= 1'b0;
    end else begin
      if (w_s3_free) begin
        r_s3_v    <= r_s2_v;
        r_s3_data <= r_s2_data;
        r_s3_rt   <= r_s2_rt;
      end
      if (w_s2_mv) begin
        r_s2_v    <= r_s1_v;
        r_s2_data <= w_dp_res;
        r_s2_rt   <= r_s1_rt;
      end
      if (w_s1_mv) begin
        r_s1_v   <= in_valid;
        r_s1_op  <= in_op;
        r_s1_ra  <= in_ra;
        r_s1_cnt <= w_cnt;
        r_s1_rt  <= in_rt;
      end
    end
  end
endmodule

// File: tb/tb_shift_rotate_pipe_ctrl.sv
// tb_shift_rotate_pipe_ctrl: directed vectors with hand-computed results for the shift-rotate pipe
module tb_shift_rotate_pipe_ctrl;
  import spu_shift_pkg::*;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  shift_op_t    in_op = SHLH;
  logic [127:0] in_ra = '0;
  logic [127:0] in_rb = '0;
  logic [6:0]   in_imm7 = '0;
  logic [6:0]   in_rt = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [6:0]   out_rt;
  logic [127:0] out_data;
  logic         busy;
  int           n_tot = 0;
  int           n_bad = 0;
  shift_rotate_pipe_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .in_imm7   (in_imm7),
    .in_rt     (in_rt),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rt    (out_rt),
    .out_data  (out_data),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_one(input string tag, input shift_op_t op, input logic [127:0] ra,
                         input logic [127:0] rb, input logic [6:0] imm, input logic [6:0] rt,
                         input logic [127:0] exp);
    int k;
    in_valid = 1'b1;
    in_op    = op;
    in_ra    = ra;
    in_rb    = rb;
    in_imm7  = imm;
    in_rt    = rt;
    #1;
    chk({tag, "_rdy"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 6) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, 128'(k), 128'd3);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_rt"}, out_rt, rt);
    tick();
    chk({tag, "_drain"}, out_valid, 1'b0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_rt", out_rt, '0);
    rst = 1'b0;
    #1;
    chk("rst_rdy", in_ready, 1'b1);
    run_one("shlhi4", SHLHI, {8{16'h0001}}, '0, 7'd4, 7'd5, {8{16'h0010}});
    run_one("shlhi7f", SHLHI, {8{16'hFFFF}}, '0, 7'h7F, 7'd6, '0);
    run_one("shlh15", SHLH, {8{16'hFFFF}}, {8{16'd15}}, 7'd0, 7'd7, {8{16'h8000}});
    run_one("shlh_mix", SHLH, {8{16'hFFFF}},
            {16'd16, 16'd17, 16'd31, 16'd32, 16'd33, 16'd0, 16'd1, 16'd15}, 7'd0, 7'd8,
            {16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFE, 16'h8000});
    run_one("shlh_idx", SHLH, {8{16'h0001}},
            {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0}, 7'd0, 7'd9,
            {16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001});
    run_one("rothi1", ROTHI, {8{16'h8001}}, '0, 7'd1, 7'd10, {8{16'h0003}});
    run_one("roth20", ROTH, {8{16'h1234}}, {8{16'd20}}, 7'd0, 7'd11, {8{16'h2341}});
    run_one("roti7f", ROTI, {4{32'h80000001}}, '0, 7'h7F, 7'd12, {4{32'hC0000000}});
    run_one("shli31", SHLI, {4{32'h00000001}}, '0, 7'd31, 7'd13, {4{32'h80000000}});
    run_one("shl_mix", SHL, {4{32'h00000003}}, {32'd32, 32'd33, 32'hFFFF0004, 32'd64}, 7'd0, 7'd14,
            {32'h0, 32'h0, 32'h30, 32'h3});
    run_one("rot40", ROT, {4{32'h12345678}}, {4{32'd40}}, 7'd0, 7'd15, {4{32'h34567812}});
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_op    = SHLI;
      in_ra    = 128'(k);
      in_imm7  = 7'd0;
      in_rt    = 7'(k);
      #1;
      chk("bp_rdy", in_ready, k < 4);
      if (k < 4) tick();
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("bp_hold_ov", out_valid, 1'b1);
      chk("bp_hold_data", out_data, 128'd1);
      chk("bp_hold_rt", out_rt, 7'd1);
      chk("bp_hold_rdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", in_ready, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk("bp_ov", out_valid, 1'b1);
      chk("bp_data", out_data, 128'(k));
      chk("bp_rt", out_rt, 7'(k));
      tick();
      in_valid = 1'b0;
    end
    chk("bp_empty_ov", out_valid, 1'b0);
    chk("bp_empty_busy", busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_op    = SHLHI;
      in_ra    = {8{16'h0001}};
      in_imm7  = 7'd1;
      in_rt    = 7'(20 + k);
      flush    = (k == 2);
      #1;
      if (k == 2) begin
        chk("fl_rdy", in_ready, 1'b0);
        chk("fl_busy_pre", busy, 1'b1);
      end
      tick();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_busy", busy, 1'b0);
    chk("fl_ov", out_valid, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fl_quiet", out_valid, 1'b0);
    end
    run_one("fl_after", ROTHI, {8{16'h8001}}, '0, 7'd1, 7'd30, {8{16'h0003}});
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_op    = SHLI;
      in_ra    = {4{32'hA5A5A5A5}};
      in_imm7  = 7'd0;
      in_rt    = 7'(40 + k);
      tick();
    end
    in_valid = 1'b0;
    chk("mr_ov_pre", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_ov", out_valid, 1'b0);
    chk("mr_data", out_data, '0);
    chk("mr_rt", out_rt, '0);
    chk("mr_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mr_rdy", in_ready, 1'b1);
    run_one("mr_shl1", SHL, {4{32'h1}}, {4{32'd1}}, 7'd0, 7'd50, {4{32'h2}});
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
